// File: rtl/rgb_timing_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb_timing_detect_pkg
// Description : Shared types and constants for the RGB timing detector.
//               Lock FSM state encoding, RGB565 field widths, coordinate and
//               measurement widths, saturation limits and saturating
//               increment helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package rgb_timing_detect_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCK   = 2'd2
    } lock_state_e;

    localparam int unsigned RED_W   = 5;
    localparam int unsigned GRN_W   = 6;
    localparam int unsigned BLU_W   = 5;
    localparam int unsigned PIX_W   = RED_W + GRN_W + BLU_W;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned MEAS_W  = 11;

    localparam logic [COORD_W-1:0] C_COORD_MAX = 10'd1023;
    localparam logic [MEAS_W-1:0]  C_MEAS_MAX  = 11'd2047;

    // One complete set of frame geometry measurements.
    typedef struct packed {
        logic [MEAS_W-1:0] h_active;
        logic [MEAS_W-1:0] h_total;
        logic [MEAS_W-1:0] v_active;
        logic [MEAS_W-1:0] v_total;
    } geom_t;

    function automatic logic [COORD_W-1:0] coord_inc(input logic [COORD_W-1:0] v);
        return (v == C_COORD_MAX) ? v : v + 10'd1;
    endfunction

    function automatic logic [MEAS_W-1:0] meas_inc(input logic [MEAS_W-1:0] v,
                                                   input logic              en);
        return (!en || v == C_MEAS_MAX) ? v : v + 11'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_timing_detect_edge.sv
`default_nettype none
// ============================================================================
// Module      : rgb_edge_det
// Description : Leading/trailing edge detector for one registered signal.
//               Keeps a one-cycle delayed copy of sig_i and compares it with
//               the current value. POL gives the active level of sig_i;
//               lead_o marks inactive->active, trail_o active->inactive.
//               RST_ACTIVE selects whether the delayed copy resets to the
//               active level (so a sync already active at reset release does
//               not look like a fresh leading edge).
// Ports       : clk, rst_n (async, active-low), sig_i (stage-1 signal),
//               lead_o, trail_o (single-cycle, combinational from registers)
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_edge_det #(
    parameter bit POL        = 1'b1,
    parameter bit RST_ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic lead_o,
    output logic trail_o
);

    logic sig_q;
    logic w_act_cur;
    logic w_act_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= RST_ACTIVE ? POL : ~POL;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign w_act_cur  = (sig_i == POL);
    assign w_act_prev = (sig_q == POL);
    assign lead_o     = w_act_cur & ~w_act_prev;
    assign trail_o    = ~w_act_cur & w_act_prev;

endmodule
`default_nettype wire

// File: rtl/rgb_timing_detect.sv
`default_nettype none
// ============================================================================
// Module      : rgb_timing_detect
// Description : RGB565 video timing detector. Registers the incoming stream
//               (stage 1), recovers pixel coordinates, measures line/frame
//               geometry and tracks its stability with a lock FSM. All
//               outputs are registered from stage 1 (stage 2), giving a fixed
//               2-cycle latency from inputs to out_*.
// Ports       : rgb_clk, rgb_rst_n (async, active-low)
//               in_hs/in_vs/in_de/in_data   - incoming stream
//               out_hs/out_vs/out_de/out_data, out_x/out_y - aligned stream
//               h_active/h_total/v_active/v_total - measured geometry
//               locked, frame_start - status
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_timing_detect
    import rgb_timing_detect_pkg::*;
#(
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic               rgb_clk,
    input  logic               rgb_rst_n,
    input  logic               in_hs,
    input  logic               in_vs,
    input  logic               in_de,
    input  logic [PIX_W-1:0]   in_data,
    output logic               out_hs,
    output logic               out_vs,
    output logic               out_de,
    output logic [PIX_W-1:0]   out_data,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [MEAS_W-1:0]  h_active,
    output logic [MEAS_W-1:0]  v_active,
    output logic [MEAS_W-1:0]  h_total,
    output logic [MEAS_W-1:0]  v_total,
    output logic               locked,
    output logic               frame_start
);

    // ---------------------------------------------------------------- stage 1
    logic             hs_s1_q, vs_s1_q, de_s1_q;
    logic [PIX_W-1:0] data_s1_q;

    // Syncs reset to their active level so that the first leading edge seen
    // after release is a genuine one.
    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            hs_s1_q   <= HS_POL;
            vs_s1_q   <= VS_POL;
            de_s1_q   <= 1'b0;
            data_s1_q <= '0;
        end else begin
            hs_s1_q   <= in_hs;
            vs_s1_q   <= in_vs;
            de_s1_q   <= in_de;
            data_s1_q <= in_data;
        end
    end

    // ---------------------------------------------------------- edge detects
    logic w_hs_lead, w_hs_trail, w_vs_lead, w_vs_trail, w_de_rise, w_de_fall;
    logic w_unused_trail;

    rgb_edge_det #(.POL(HS_POL), .RST_ACTIVE(1'b1)) u_hs_edge (
        .clk(rgb_clk), .rst_n(rgb_rst_n), .sig_i(hs_s1_q),
        .lead_o(w_hs_lead), .trail_o(w_hs_trail)
    );

    rgb_edge_det #(.POL(VS_POL), .RST_ACTIVE(1'b1)) u_vs_edge (
        .clk(rgb_clk), .rst_n(rgb_rst_n), .sig_i(vs_s1_q),
        .lead_o(w_vs_lead), .trail_o(w_vs_trail)
    );

    rgb_edge_det #(.POL(1'b1), .RST_ACTIVE(1'b0)) u_de_edge (
        .clk(rgb_clk), .rst_n(rgb_rst_n), .sig_i(de_s1_q),
        .lead_o(w_de_rise), .trail_o(w_de_fall)
    );

    assign w_unused_trail = w_hs_trail ^ w_vs_trail;

    // --------------------------------------------------- counters (next state)
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               open_q, open_d;       // a DE line started in this frame
    logic [MEAS_W-1:0]  dcnt_q, dcnt_d;       // DE cycles in current line
    logic [MEAS_W-1:0]  hclk_q, hclk_d;       // clocks since last hs edge
    logic [MEAS_W-1:0]  lcnt_q, lcnt_d;       // completed lines since vs edge
    logic [MEAS_W-1:0]  hcnt_q, hcnt_d;       // hs edges since vs edge
    geom_t              meas_q, meas_d, snap_q, snap_d;
    logic               w_line_end;

    always_comb begin
        // A DE fall only closes a line if that line began in this frame; a
        // line cut by a vs edge does not count.
        w_line_end = w_de_fall & open_q;

        x_d = '0;
        if (de_s1_q) begin
            x_d = w_de_rise ? '0 : coord_inc(x_q);
        end

        open_d = open_q;
        if (w_de_rise) begin
            open_d = 1'b1;
        end else if (w_vs_lead || w_de_fall) begin
            open_d = 1'b0;
        end

        y_d = y_q;
        if (w_vs_lead) begin
            y_d = '0;
        end else if (w_line_end) begin
            y_d = coord_inc(y_q);
        end

        dcnt_d = dcnt_q;
        if (de_s1_q) begin
            dcnt_d = w_de_rise ? 11'd1 : meas_inc(dcnt_q, 1'b1);
        end

        meas_d = meas_q;
        if (w_de_fall) begin
            meas_d.h_active = dcnt_q;
        end

        hclk_d = w_hs_lead ? '0 : meas_inc(hclk_q, 1'b1);
        if (w_hs_lead) begin
            meas_d.h_total = meas_inc(hclk_q, 1'b1);
        end

        // Coincident hs/de-fall events are folded into the frame totals.
        lcnt_d = w_vs_lead ? '0 : meas_inc(lcnt_q, w_line_end);
        hcnt_d = w_vs_lead ? '0 : meas_inc(hcnt_q, w_hs_lead);
        if (w_vs_lead) begin
            meas_d.v_active = meas_inc(lcnt_q, w_line_end);
            meas_d.v_total  = meas_inc(hcnt_q, w_hs_lead);
        end
    end

    // --------------------------------------------------------------- lock FSM
    lock_state_e state_q, state_d;
    logic        w_snap_en;
    logic        w_match;

    // The FSM judges the measurements as they stand after this edge's update.
    assign w_match = (meas_d == snap_q);

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            state_q <= ST_UNLOCK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_snap_en = 1'b0;
        if (w_vs_lead) begin
            case (state_q)
                ST_UNLOCK: begin
                    w_snap_en = 1'b1;
                    state_d   = ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_match) begin
                        state_d = ST_LOCK;
                    end else begin
                        w_snap_en = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (!w_match) begin
                        state_d = ST_UNLOCK;
                    end
                end
                default: begin
                    state_d = ST_UNLOCK;
                end
            endcase
        end
        snap_d = w_snap_en ? meas_d : snap_q;
    end

    // ------------------------------------------------------------- stage 2
    logic             out_hs_q, out_vs_q, out_de_q, frame_start_q, locked_q;
    logic [PIX_W-1:0] out_data_q;

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            out_hs_q      <= 1'b0;
            out_vs_q      <= 1'b0;
            out_de_q      <= 1'b0;
            out_data_q    <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            open_q        <= 1'b0;
            dcnt_q        <= '0;
            hclk_q        <= '0;
            lcnt_q        <= '0;
            hcnt_q        <= '0;
            meas_q        <= '0;
            snap_q        <= '0;
        end else begin
            out_hs_q      <= hs_s1_q;
            out_vs_q      <= vs_s1_q;
            out_de_q      <= de_s1_q;
            out_data_q    <= data_s1_q;
            frame_start_q <= w_vs_lead;
            locked_q      <= (state_d == ST_LOCK);
            x_q           <= x_d;
            y_q           <= y_d;
            open_q        <= open_d;
            dcnt_q        <= dcnt_d;
            hclk_q        <= hclk_d;
            lcnt_q        <= lcnt_d;
            hcnt_q        <= hcnt_d;
            meas_q        <= meas_d;
            snap_q        <= snap_d;
        end
    end

    assign out_hs      = out_hs_q;
    assign out_vs      = out_vs_q;
    assign out_de      = out_de_q;
    assign out_data    = out_data_q;
    assign out_x       = x_q;
    assign out_y       = y_q;
    assign h_active    = meas_q.h_active;
    assign h_total     = meas_q.h_total;
    assign v_active    = meas_q.v_active;
    assign v_total     = meas_q.v_total;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire
